temp_spi_sampler: RTL and testbench

TEMP_SPI_SAMPLER -- requirements
Module: temp_spi_sampler

---
 rtl/temp_spi_pkg.sv | 27 ++
 rtl/temp_avg_buf.sv | 57 +++++
 rtl/temp_spi_sampler.sv | 187 ++++++++++++++++++
 tb/tb_temp_spi_sampler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_spi_pkg.sv
// temp_spi_pkg
//   Shared definitions for the SPI temperature sampler:
//   - default values for the sampler parameters
//   - the conversion FSM state type
//   - cnt_width(), the counter width needed to count 0..n-1
package temp_spi_pkg;

  localparam int FRAME_W_DEF  = 16;
  localparam int DATA_W_DEF   = 11;
  localparam int DIV_DEF      = 2;
  localparam int PERIOD_DEF   = 1024;
  localparam int AVG_LOG2_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } state_t;

  // Never returns 0, so a counter that only ever holds 0 still gets one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/temp_avg_buf.sv
// temp_avg_buf
//   Moving average over the last 2^AVG_LOG2 samples. It keeps a circular
//   buffer and a running sum. The mean is the sum shifted right
//   arithmetically, so it rounds toward minus infinity.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset; clears buffer, sum, fill
//   sample  in   signed sample, DATA_W bits
//   strobe  in   one-cycle pulse that pushes sample into the buffer
//   mean    out  signed floor(sum / 2^AVG_LOG2), DATA_W bits
//   full    out  buffer has received 2^AVG_LOG2 samples since reset
module temp_avg_buf
  import temp_spi_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] sample,
  input  logic                     strobe,
  output logic signed [DATA_W-1:0] mean,
  output logic                     full
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = DATA_W + AVG_LOG2;
  localparam int PTR_W  = cnt_width(DEPTH);
  localparam int FILL_W = AVG_LOG2 + 1;

  logic signed [DATA_W-1:0] buf_mem [DEPTH];
  logic        [PTR_W-1:0]  wr_ptr;
  logic        [FILL_W-1:0] fill;
  logic signed [SUM_W-1:0]  sum;

  // The slot about to be overwritten holds the oldest sample, or zero while
  // the buffer is still filling. Subtracting it therefore keeps the sum
  // correct without a separate fill-phase path.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) buf_mem[i] <= '0;
      wr_ptr <= '0;
      fill   <= '0;
      sum    <= '0;
    end else if (strobe) begin
      buf_mem[wr_ptr] <= sample;
      sum    <= sum + SUM_W'(sample) - SUM_W'(buf_mem[wr_ptr]);
      wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (!full) fill <= fill + FILL_W'(1);
    end
  end

  assign full = (fill == FILL_W'(DEPTH));
  assign mean = DATA_W'(sum >>> AVG_LOG2);

endmodule

// File: rtl/temp_spi_sampler.sv
// temp_spi_sampler
//   SPI mode-0 master that reads a temperature sensor frame. A conversion
//   starts on a start request, or on a periodic tick when auto_en is high.
//   The signed top DATA_W bits of each frame go into a moving average.
//   The module also raises a hysteretic over-temperature alarm.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   start       in   one-cycle conversion request; ignored while busy
//   auto_en     in   enables a conversion every PERIOD clk cycles
//   miso        in   sensor serial data, MSB first
//   thr_hi      in   signed alarm set threshold   (temp >  thr_hi sets)
//   thr_lo      in   signed alarm clear threshold (temp <  thr_lo clears)
//   cs_n        out  active-low chip select
//   sck         out  SPI clock, idle low
//   temp        out  signed averaged temperature, held between updates
//   temp_valid  out  one-cycle pulse when temp updates
//   busy        out  high whenever a conversion is in progress
//   alarm       out  over-temperature flag
module temp_spi_sampler
  import temp_spi_pkg::*;
#(
  parameter int FRAME_W  = FRAME_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DIV      = DIV_DEF,
  parameter int PERIOD   = PERIOD_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     auto_en,
  input  logic                     miso,
  input  logic signed [DATA_W-1:0] thr_hi,
  input  logic signed [DATA_W-1:0] thr_lo,
  output logic                     cs_n,
  output logic                     sck,
  output logic signed [DATA_W-1:0] temp,
  output logic                     temp_valid,
  output logic                     busy,
  output logic                     alarm
);

  localparam int DIV_W  = cnt_width(DIV);
  localparam int HALF_W = cnt_width(2 * FRAME_W);
  localparam int PER_W  = cnt_width(PERIOD);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * FRAME_W - 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD - 1);

  state_t                   state, state_next;
  logic        [DIV_W-1:0]  div_cnt;
  logic        [HALF_W-1:0] half_cnt;
  logic        [PER_W-1:0]  per_cnt;
  logic        [FRAME_W-1:0] shreg;
  logic                     pending;
  logic                     tick;
  logic                     phase_end;
  logic                     launch;
  logic                     rise_edge;
  logic                     frame_done;
  logic                     hold_done;
  logic signed [DATA_W-1:0] sample;
  logic signed [DATA_W-1:0] mean;
  logic                     avg_full;

  assign tick       = auto_en && (per_cnt == PER_LAST);
  assign phase_end  = (div_cnt == DIV_LAST);
  assign launch     = (state == ST_IDLE) && (start || tick || pending);
  assign frame_done = (state == ST_SHIFT) && phase_end && (half_cnt == HALF_LAST);
  assign hold_done  = (state == ST_HOLD) && phase_end;

  // SHIFT opens with sck high, so the rise leaving SETUP is the first one.
  // Each later rise follows an odd (low) half-period, except after the
  // final half-period, which returns sck low for HOLD.
  assign rise_edge = ((state == ST_SETUP) && phase_end) ||
                     ((state == ST_SHIFT) && phase_end && half_cnt[0] &&
                      (half_cnt != HALF_LAST));

  assign sample = shreg[FRAME_W-1 -: DATA_W];

  // The period counter only runs while auto_en is high. It restarts from
  // zero each time auto_en goes high again.
  always_ff @(posedge clk) begin
    if (rst || !auto_en || tick) per_cnt <= '0;
    else                         per_cnt <= per_cnt + PER_W'(1);
  end

  // A tick that arrives mid-conversion is remembered once. The flag is
  // consumed by whichever launch happens next in IDLE.
  always_ff @(posedge clk) begin
    if (rst || launch) pending <= 1'b0;
    else if (tick)     pending <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    cs_n       = 1'b1;
    sck        = 1'b0;
    busy       = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (launch) state_next = ST_SETUP;
      end
      ST_SETUP: begin
        cs_n = 1'b0;
        if (phase_end) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        cs_n = 1'b0;
        sck  = ~half_cnt[0];
        if (frame_done) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (phase_end) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // div_cnt times each phase of DIV clk cycles. half_cnt counts sck
  // half-periods, and only during SHIFT.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      half_cnt <= '0;
    end else begin
      if ((state == ST_IDLE) || (state == ST_DONE) || phase_end) div_cnt <= '0;
      else                                                       div_cnt <= div_cnt + DIV_W'(1);
      if (state != ST_SHIFT) half_cnt <= '0;
      else if (phase_end)    half_cnt <= half_cnt + HALF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            shreg <= '0;
    else if (rise_edge) shreg <= {shreg[FRAME_W-2:0], miso};
  end

  // The sample is pushed only when the last half-period completes. An abort
  // by rst mid-frame therefore never reaches the buffer.
  temp_avg_buf #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk    (clk),
    .rst    (rst),
    .sample (sample),
    .strobe (frame_done),
    .mean   (mean),
    .full   (avg_full)
  );

  // The averager was updated at the end of SHIFT, so mean is settled by the
  // end of HOLD. Registering here makes temp, alarm and temp_valid all
  // change together on entry to DONE. The set test is checked first, so it
  // wins when the thresholds are inverted.
  always_ff @(posedge clk) begin
    if (rst) begin
      temp       <= '0;
      temp_valid <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      temp_valid <= hold_done && avg_full;
      if (hold_done && avg_full) begin
        temp <= mean;
        if (mean > thr_hi)      alarm <= 1'b1;
        else if (mean < thr_lo) alarm <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_temp_spi_sampler.sv
// tb_temp_spi_sampler
//   Drives temp_spi_sampler through a sensor model.
//   The reference averager is a queue of the last 2^AVG_LOG2 completed
//   samples. Its mean is computed with integer floor division, and the alarm
//   follows the threshold rules. Conversion timing is compared against
//   cycle counts derived from the frame/divider parameters.
module tb_temp_spi_sampler;

  localparam int FRAME_W  = 16;
  localparam int DATA_W   = 11;
  localparam int DIV      = 2;
  localparam int PERIOD   = 50;
  localparam int AVG_LOG2 = 2;
  localparam int DEPTH    = 1 << AVG_LOG2;

  localparam int CS_LOW_CYCLES = DIV * (2 * FRAME_W + 1);
  localparam int VALID_LAT     = 1 + DIV * (2 * FRAME_W + 2);

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic                     auto_en;
  logic                     miso;
  logic signed [DATA_W-1:0] thr_hi;
  logic signed [DATA_W-1:0] thr_lo;
  logic                     cs_n;
  logic                     sck;
  logic signed [DATA_W-1:0] temp;
  logic                     temp_valid;
  logic                     busy;
  logic                     alarm;

  temp_spi_sampler #(
    .FRAME_W  (FRAME_W),
    .DATA_W   (DATA_W),
    .DIV      (DIV),
    .PERIOD   (PERIOD),
    .AVG_LOG2 (AVG_LOG2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .auto_en    (auto_en),
    .miso       (miso),
    .thr_hi     (thr_hi),
    .thr_lo     (thr_lo),
    .cs_n       (cs_n),
    .sck        (sck),
    .temp       (temp),
    .temp_valid (temp_valid),
    .busy       (busy),
    .alarm      (alarm)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic [FRAME_W-1:0] frame_q[$];
  logic [FRAME_W-1:0] tx_shreg;
  logic [FRAME_W-1:0] cur_frame;
  int                 rises = 0;
  int                 hist[$];
  bit                 alarm_m = 1'b0;

  task automatic checkOutput(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [FRAME_W-1:0] mkFrame(input int s);
    logic [DATA_W-1:0]         field = DATA_W'(s);
    logic [FRAME_W-DATA_W-1:0] junk  = (FRAME_W-DATA_W)'($urandom);
    return {field, junk};
  endfunction

  function automatic int sampleOf(input logic [FRAME_W-1:0] f);
    logic signed [DATA_W-1:0] field = f[FRAME_W-1 -: DATA_W];
    return int'(field);
  endfunction

  function automatic int floorDiv(input int a, input int b);
    int q = a / b;
    if ((a % b != 0) && (a < 0)) q -= 1;
    return q;
  endfunction

  function automatic int modelMean();
    int s = 0;
    foreach (hist[i]) s += hist[i];
    return floorDiv(s, DEPTH);
  endfunction

  // The sensor loads a new frame when cs_n falls. It presents the MSB
  // first and moves to the next bit on every sck fall.
  always @(negedge cs_n) begin
    rises = 0;
    if (frame_q.size() > 0) tx_shreg = frame_q.pop_front();
    else                    tx_shreg = '0;
    cur_frame = tx_shreg;
    miso      = tx_shreg[FRAME_W-1];
  end

  always @(negedge sck) begin
    tx_shreg = tx_shreg << 1;
    miso     = tx_shreg[FRAME_W-1];
  end

  always @(posedge sck) rises++;

  // A frame counts only if all of its bits were clocked out before cs_n
  // rose again.
  always @(posedge cs_n) begin
    if (rises == FRAME_W && rst === 1'b0) begin
      hist.push_back(sampleOf(cur_frame));
      if (hist.size() > DEPTH) void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (temp_valid === 1'b1 && rst === 1'b0) begin
      int exp_t;
      exp_t = modelMean();
      if (exp_t > int'(thr_hi))      alarm_m = 1'b1;
      else if (exp_t < int'(thr_lo)) alarm_m = 1'b0;
      checkOutput("fill_at_valid", hist.size(), DEPTH);
      checkOutput("temp", int'(temp), exp_t);
      checkOutput("alarm", int'(alarm), int'(alarm_m));
    end
  end

  task automatic applyStimulus(input int smp, input bit noisy);
    int n = 1;
    int cs_low = 0;
    int valid_n = 0;
    int valid_cnt = 0;
    int busy_cnt = 0;
    frame_q.push_back(mkFrame(smp));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (n < 300) begin
      if (cs_n === 1'b0)       cs_low++;
      if (temp_valid === 1'b1) begin valid_cnt++; valid_n = n; end
      if (busy !== 1'b1) break;
      busy_cnt++;
      start = noisy && (n <= VALID_LAT - 3) && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checkOutput("busy_cycles", busy_cnt, VALID_LAT);
    checkOutput("cs_low_cycles", cs_low, CS_LOW_CYCLES);
    checkOutput("sck_rises", rises, FRAME_W);
    if (hist.size() == DEPTH) begin
      checkOutput("valid_count", valid_cnt, 1);
      checkOutput("valid_latency", valid_n, VALID_LAT);
    end else begin
      checkOutput("valid_while_filling", valid_cnt, 0);
    end
  endtask

  task automatic checkResetState(input string where);
    checkOutput({where, "_cs_n"}, int'(cs_n), 1);
    checkOutput({where, "_sck"}, int'(sck), 0);
    checkOutput({where, "_busy"}, int'(busy), 0);
    checkOutput({where, "_temp"}, int'(temp), 0);
    checkOutput({where, "_temp_valid"}, int'(temp_valid), 0);
    checkOutput({where, "_alarm"}, int'(alarm), 0);
  endtask

  task automatic abortMidFrame();
    int n = 0;
    frame_q.push_back(mkFrame(300));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (rises < 8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abort_reached_bit7", rises, 8);
    rst = 1'b1;
    hist.delete();
    alarm_m = 1'b0;
    @(negedge clk);
    checkResetState("abort");
    rst = 1'b0;
    frame_q.delete();
  endtask

  task automatic autoRun();
    int   m = 0;
    int   falls = 0;
    int   last_fall = 0;
    int   quiet = 0;
    logic prev_cs;
    for (int i = 0; i < 8; i++) frame_q.push_back(mkFrame(int'($urandom_range(0, 2047)) - 1024));
    @(negedge clk);
    auto_en = 1'b1;
    prev_cs = cs_n;
    while (falls < 4 && m < 1000) begin
      @(negedge clk);
      m++;
      if (prev_cs === 1'b1 && cs_n === 1'b0) begin
        falls++;
        if (falls == 1) checkOutput("auto_first_launch", m, PERIOD);
        else            checkOutput("auto_spacing", m - last_fall, VALID_LAT + 1);
        last_fall = m;
      end
      prev_cs = cs_n;
      start = (busy === 1'b1) && ($urandom_range(0, 3) == 0);
    end
    start = 1'b0;
    auto_en = 1'b0;
    checkOutput("auto_conversions", falls, 4);
    while (quiet < 3 && m < 2000) begin
      @(negedge clk);
      m++;
      quiet = (busy === 1'b1) ? 0 : quiet + 1;
    end
    checkOutput("auto_drain", quiet, 3);
    frame_q.delete();
  endtask

  initial begin
    int vals_a[5] = '{100, 100, 104, 104, 108};
    rst = 1'b1; start = 1'b0; auto_en = 1'b0; miso = 1'b0;
    thr_hi = 11'sd100; thr_lo = 11'sd90;
    repeat (3) @(negedge clk);
    checkResetState("por");
    rst = 1'b0;

    $display("[TB] averaging and fill phase");
    foreach (vals_a[i]) begin
      applyStimulus(vals_a[i], 1'b0);
      if (i == 3) checkOutput("avg_first_full", int'(temp), 102);
      if (i == 4) checkOutput("avg_fifth", int'(temp), 104);
    end

    $display("[TB] alarm hysteresis");
    repeat (4) applyStimulus(101, 1'b0);
    checkOutput("alarm_after_101", int'(alarm), 1);
    repeat (4) applyStimulus(95, 1'b0);
    checkOutput("alarm_after_95", int'(alarm), 1);
    repeat (4) applyStimulus(89, 1'b0);
    checkOutput("alarm_after_89", int'(alarm), 0);

    $display("[TB] negative values and floor rounding");
    repeat (4) applyStimulus(-4, 1'b0);
    checkOutput("neg_four", int'(temp), -4);
    applyStimulus(-3, 1'b0);
    checkOutput("neg_floor", int'(temp), -4);

    $display("[TB] range extremes");
    repeat (4) applyStimulus(1023, 1'b0);
    checkOutput("max_sample", int'(temp), 1023);
    repeat (4) applyStimulus(-1024, 1'b0);
    checkOutput("min_sample", int'(temp), -1024);

    $display("[TB] random samples and thresholds, starts while busy");
    for (int i = 0; i < 14; i++) begin
      thr_hi = DATA_W'(int'($urandom_range(0, 400)) - 200);
      thr_lo = DATA_W'(int'($urandom_range(0, 400)) - 200);
      if (i % 2 == 0) applyStimulus(int'($urandom_range(0, 2047)) - 1024, 1'b1);
      else            applyStimulus(int'($urandom_range(0, 400)) - 200, 1'b1);
    end

    $display("[TB] reset mid-frame");
    thr_hi = 11'sd100; thr_lo = 11'sd90;
    repeat (4) applyStimulus(500, 1'b0);
    checkOutput("pre_abort_alarm", int'(alarm), 1);
    abortMidFrame();
    applyStimulus(100, 1'b0);
    applyStimulus(100, 1'b0);
    applyStimulus(104, 1'b0);
    checkOutput("post_abort_temp_held", int'(temp), 0);
    applyStimulus(104, 1'b0);
    checkOutput("post_abort_avg", int'(temp), 102);

    $display("[TB] periodic conversions");
    autoRun();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
